line_buffer3: RTL and testbench

Three-row line buffer feeding the convolution window. It accepts a raster-order pixel stream, stores rows in a four-bank circular row store, and presents one vertically aligned 3-pixel column per `shift_buffer` request on `in_l1`/`in_l2`/`in_l3` (top/mid/bottom). It is the producer end of the `shift_buffer`/`in_l*` interface that the convolve controller consumes. It sits between the pixel source (DMA/input FIFO) and the convolve block.

---
 rtl/npu_pkg.sv | 14 +
 rtl/lb_row_bank.sv | 23 ++
 rtl/line_buffer3.sv | 169 ++++++++++++++++
 tb/tb_line_buffer3.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types and defaults used by the line buffer and its row banks.
package npu_pkg;

  localparam int BIT_DEPTH = 8;

  typedef enum logic [1:0] {
    WAIT_ROWS,
    STREAM,
    FRAME_END
  } lb_state_t;

  typedef logic [1:0] bank_idx_t;

endpackage

// File: rtl/lb_row_bank.sv
// One image row of storage: synchronous write, asynchronous read, no reset.
module lb_row_bank #(
  parameter int BIT_DEPTH = npu_pkg::BIT_DEPTH,
  parameter int IMG_WIDTH = 28,
  parameter int AW        = $clog2(IMG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        wr_addr,
  input  logic [BIT_DEPTH-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [BIT_DEPTH-1:0] rd_data
);

  logic [BIT_DEPTH-1:0] mem [IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/line_buffer3.sv
// Three-row line buffer over four rotating row banks; column read is combinational, row_done/frame_done one cycle after the consuming edge.
// pix_ready drops while four rows are held or the frame is fully written; LINE_BUFFER_ZERO_PAD_EN adds a zero column at each row end.
module line_buffer3 #(
  parameter int BIT_DEPTH  = npu_pkg::BIT_DEPTH,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic [BIT_DEPTH-1:0] pix_in,
  output logic                 pix_ready,
  input  logic                 shift_buffer,
  output logic [BIT_DEPTH-1:0] in_l1,
  output logic [BIT_DEPTH-1:0] in_l2,
  output logic [BIT_DEPTH-1:0] in_l3,
  output logic                 col_valid,
  output logic                 row_done,
  output logic                 frame_done
);
  import npu_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
`ifdef LINE_BUFFER_ZERO_PAD_EN
  localparam int RD_COLS = IMG_WIDTH + 2;
`else
  localparam int RD_COLS = IMG_WIDTH;
`endif
  localparam int RCW = $clog2(RD_COLS);
  localparam logic [CW-1:0]  WR_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RCW-1:0] RD_LAST  = RCW'(RD_COLS - 1);
  localparam logic [RW-1:0]  ROWS_H   = RW'(IMG_HEIGHT);
  localparam logic [RW-1:0]  OUT_LAST = RW'(IMG_HEIGHT - 3);

  lb_state_t            state;
  logic [CW-1:0]        wr_col;
  bank_idx_t            wr_bank;
  bank_idx_t            rd_bank;
  logic [RCW-1:0]       rd_col;
  logic [2:0]           rows_avail;
  logic [2:0]           rows_avail_nxt;
  logic [RW-1:0]        rows_written;
  logic [RW-1:0]        out_rows;
  logic                 wr_fire, wr_row_end, rd_fire, rd_row_end;
  logic                 pad_col;
  logic [CW-1:0]        rd_addr;
  logic [BIT_DEPTH-1:0] bank_rd [4];

  assign pix_ready  = (rows_avail < 3'd4) && (rows_written < ROWS_H) && (state != FRAME_END);
  assign wr_fire    = pix_valid && pix_ready;
  assign wr_row_end = wr_fire && (wr_col == WR_LAST);
  assign rd_fire    = shift_buffer && col_valid;
  assign rd_row_end = rd_fire && (rd_col == RD_LAST);

  // Row completion and row release in the same cycle cancel out.
  always_comb begin
    rows_avail_nxt = rows_avail;
    case ({wr_row_end, rd_row_end})
      2'b10:   rows_avail_nxt = rows_avail + 3'd1;
      2'b01:   rows_avail_nxt = rows_avail - 3'd1;
      default: rows_avail_nxt = rows_avail;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_ROWS;
      wr_col       <= '0;
      wr_bank      <= '0;
      rd_col       <= '0;
      rd_bank      <= '0;
      rows_avail   <= '0;
      rows_written <= '0;
      out_rows     <= '0;
      col_valid    <= 1'b0;
      row_done     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      rows_avail <= rows_avail_nxt;
      if (wr_fire) begin
        if (wr_row_end) begin
          wr_col       <= '0;
          wr_bank      <= wr_bank + 2'd1;
          rows_written <= rows_written + RW'(1);
        end else begin
          wr_col <= wr_col + CW'(1);
        end
      end
      case (state)
        // Looking at the next-cycle row count lets col_valid rise right after the third row lands.
        WAIT_ROWS: begin
          if (rows_avail_nxt >= 3'd3) begin
            state     <= STREAM;
            col_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (rd_fire) begin
            if (rd_row_end) begin
              rd_col   <= '0;
              rd_bank  <= rd_bank + 2'd1;
              out_rows <= out_rows + RW'(1);
              row_done <= 1'b1;
              if (out_rows == OUT_LAST) begin
                state      <= FRAME_END;
                col_valid  <= 1'b0;
                frame_done <= 1'b1;
              end else if (rows_avail_nxt < 3'd3) begin
                state     <= WAIT_ROWS;
                col_valid <= 1'b0;
              end
            end else begin
              rd_col <= rd_col + RCW'(1);
            end
          end
        end
        FRAME_END: begin
          state        <= WAIT_ROWS;
          wr_col       <= '0;
          wr_bank      <= '0;
          rd_col       <= '0;
          rd_bank      <= '0;
          rows_avail   <= '0;
          rows_written <= '0;
          out_rows     <= '0;
        end
        default: state <= WAIT_ROWS;
      endcase
    end
  end

`ifdef LINE_BUFFER_ZERO_PAD_EN
  assign pad_col = (rd_col == '0) || (rd_col == RD_LAST);
  assign rd_addr = CW'(rd_col - RCW'(1));
`else
  assign pad_col = 1'b0;
  assign rd_addr = CW'(rd_col);
`endif

  for (genvar b = 0; b < 4; b++) begin : g_bank
    lb_row_bank #(
      .BIT_DEPTH (BIT_DEPTH),
      .IMG_WIDTH (IMG_WIDTH),
      .AW        (CW)
    ) u_bank (
      .clk     (clk),
      .we      (wr_fire && (wr_bank == bank_idx_t'(b))),
      .wr_addr (wr_col),
      .wr_data (pix_in),
      .rd_addr (rd_addr),
      .rd_data (bank_rd[b])
    );
  end

  always_comb begin
    in_l1 = '0;
    in_l2 = '0;
    in_l3 = '0;
    if (col_valid && !pad_col) begin
      in_l1 = bank_rd[rd_bank];
      in_l2 = bank_rd[rd_bank + 2'd1];
      in_l3 = bank_rd[rd_bank + 2'd2];
    end
  end

endmodule

// File: tb/tb_line_buffer3.sv
// Bench for line_buffer3 at 4x4: directed raster streams plus random traffic against a frame-level reference model.
module tb_line_buffer3;

  localparam int W = 4;
  localparam int H = 4;
`ifdef LINE_BUFFER_ZERO_PAD_EN
  localparam int RC = W + 2;
  localparam bit PAD = 1'b1;
`else
  localparam int RC = W;
  localparam bit PAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic       pix_ready;
  logic       shift_buffer;
  logic [7:0] in_l1, in_l2, in_l3;
  logic       col_valid, row_done, frame_done;

  line_buffer3 #(.BIT_DEPTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_in       (pix_in),
    .pix_ready    (pix_ready),
    .shift_buffer (shift_buffer),
    .in_l1        (in_l1),
    .in_l2        (in_l2),
    .in_l3        (in_l3),
    .col_valid    (col_valid),
    .row_done     (row_done),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  wire [27:0] obs = {col_valid, pix_ready, row_done, frame_done, in_l1, in_l2, in_l3};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the frame as a flat pixel array, counts of pixels taken and columns consumed.
  logic [7:0] pix_mem [W*H];
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit m_row_done = 0, m_frame_done = 0, m_frame_end = 0;

  function automatic bit m_valid();
    int full, outr;
    full = wr_cnt / W;
    outr = rd_cnt / RC;
    return !m_frame_end && (full - outr) >= 3 && outr < H - 2;
  endfunction

  function automatic bit m_ready();
    int full, outr;
    full = wr_cnt / W;
    outr = rd_cnt / RC;
    return !m_frame_end && (full - outr) < 4 && full < H;
  endfunction

  function automatic logic [27:0] exp_vec();
    int c, cc, r;
    logic [7:0] p0, p1, p2;
    p0 = '0; p1 = '0; p2 = '0;
    if (m_valid()) begin
      c = rd_cnt % RC;
      r = rd_cnt / RC;
      cc = PAD ? ((c == 0 || c == RC - 1) ? -1 : c - 1) : c;
      if (cc >= 0) begin
        p0 = pix_mem[r*W + cc];
        p1 = pix_mem[(r+1)*W + cc];
        p2 = pix_mem[(r+2)*W + cc];
      end
    end
    return {m_valid(), m_ready(), m_row_done, m_frame_done, p0, p1, p2};
  endfunction

  // Apply the effect of the coming clock edge, given the inputs now on the pins.
  task automatic model_step();
    bit v, rdy, nrow, nframe;
    v = m_valid();
    rdy = m_ready();
    nrow = 0;
    nframe = 0;
    if (rst || m_frame_end) begin
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      if (pix_valid && rdy) begin
        pix_mem[wr_cnt] = pix_in;
        wr_cnt++;
      end
      if (shift_buffer && v) begin
        if (rd_cnt % RC == RC - 1) begin
          nrow = 1;
          if (rd_cnt / RC == H - 3) nframe = 1;
        end
        rd_cnt++;
      end
    end
    m_row_done = nrow;
    m_frame_done = nframe;
    m_frame_end = nframe;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; pix_valid = 0; pix_in = 0; shift_buffer = 0;
    @(negedge clk);
    advance();
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready got %b want 1", pix_ready); end
    n_checks++;
    if ({col_valid, row_done, frame_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {col_valid, row_done, frame_done});
    end
    n_checks++;
    if ({in_l1, in_l2, in_l3} !== 24'h0) begin
      n_fail++; $display("FAIL reset_cols got %h want 000000", {in_l1, in_l2, in_l3});
    end
    advance();
  endtask

  task automatic test_fill(input string tag);
    logic [23:0] first_col;
    first_col = PAD ? 24'h000000 : 24'h000408;
    for (int i = 0; i < W*H; i++) begin
      pix_valid = 1; pix_in = 8'(i); shift_buffer = 0;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL %s_cycle%0d got %h want %h", tag, i, obs, exp_vec()); end
      if (i == 12) begin
        n_checks++;
        if ({col_valid, in_l1, in_l2, in_l3} !== {1'b1, first_col}) begin
          n_fail++; $display("FAIL %s_first_col got %h want %h", tag, {col_valid, in_l1, in_l2, in_l3}, {1'b1, first_col});
        end
      end
      advance();
    end
    pix_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({pix_ready, col_valid} !== 2'b01) begin
      n_fail++; $display("FAIL %s_full got ready/valid %b want 01", tag, {pix_ready, col_valid});
    end
    advance();
  endtask

  task automatic test_consume_row();
    logic [23:0] want;
    for (int c = 0; c < RC; c++) begin
      shift_buffer = 1;
      @(negedge clk);
      if (PAD && (c == 0 || c == RC - 1)) want = 24'h0;
      else want = {8'(c - int'(PAD)), 8'(c - int'(PAD) + 4), 8'(c - int'(PAD) + 8)};
      n_checks++;
      if ({in_l1, in_l2, in_l3} !== want || obs !== exp_vec()) begin
        n_fail++; $display("FAIL consume_col%0d got %h want %h (vec %h/%h)", c, {in_l1, in_l2, in_l3}, want, obs, exp_vec());
      end
      advance();
    end
    shift_buffer = 0;
    @(negedge clk);
    want = PAD ? 24'h0 : 24'h04080c;
    n_checks++;
    if ({row_done, col_valid, in_l1, in_l2, in_l3} !== {2'b11, want}) begin
      n_fail++; $display("FAIL consume_row_done got %h want %h", {row_done, col_valid, in_l1, in_l2, in_l3}, {2'b11, want});
    end
    advance();
  endtask

  task automatic test_frame_end();
    for (int c = 0; c < RC; c++) begin
      shift_buffer = 1;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL frame_col%0d got %h want %h", c, obs, exp_vec()); end
      advance();
    end
    shift_buffer = 0;
    @(negedge clk);
    n_checks++;
    if ({row_done, frame_done, col_valid} !== 3'b110) begin
      n_fail++; $display("FAIL frame_done_pulse got %b want 110", {row_done, frame_done, col_valid});
    end
    advance();
    @(negedge clk);
    n_checks++;
    if ({pix_ready, col_valid, frame_done} !== 3'b100) begin
      n_fail++; $display("FAIL frame_restart got %b want 100", {pix_ready, col_valid, frame_done});
    end
    advance();
  endtask

  task automatic test_throttled();
    int frames = 0;
    for (int i = 0; i < 240; i++) begin
      pix_valid = (i % 3 == 0); pix_in = 8'($urandom); shift_buffer = 1;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL throttled_cycle%0d got %h want %h", i, obs, exp_vec()); end
      if (frame_done === 1'b1) frames++;
      advance();
    end
    n_checks++;
    if (frames < 3) begin n_fail++; $display("FAIL throttled_frames got %0d want >=3", frames); end
    pix_valid = 0; shift_buffer = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      pix_valid = 1'($urandom); pix_in = 8'($urandom); shift_buffer = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_cycle%0d got %h want %h", i, obs, exp_vec()); end
      advance();
    end
    pix_valid = 0; shift_buffer = 0;
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 6; i++) begin
      pix_valid = 1; pix_in = 8'(100 + i); shift_buffer = 0;
      @(negedge clk);
      advance();
    end
    pix_valid = 0; rst = 1;
    @(negedge clk);
    advance();
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (obs !== {4'b0100, 24'h0}) begin n_fail++; $display("FAIL midreset_outputs got %h want %h", obs, {4'b0100, 24'h0}); end
    advance();
    test_fill("restream");
    test_consume_row();
  endtask

  initial begin
    test_reset();
    test_fill("fill");
    test_consume_row();
    test_frame_end();
    test_throttled();
    test_random();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
